// File: rtl/arb_pkg.sv
// Shared constants, FSM encoding and rotate helper for the round-robin arbiter.
package arb_pkg;
   localparam int NREQ = 8;
   localparam int IDW  = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Rotate right so that bit 'sh' of v lands at index 0.
   function automatic logic [NREQ-1:0] rotr(input logic [NREQ-1:0] v, input logic [IDW-1:0] sh);
      logic [2*NREQ-1:0] d;
      d = {v, v} >> sh;
      return d[NREQ-1:0];
   endfunction
endpackage

// File: rtl/pri_enc8_lsb.sv
// Combinational 8-to-3 priority encoder; the lowest set index wins.
module pri_enc8_lsb
   import arb_pkg::*;
(
   input  logic [NREQ-1:0] vec,
   output logic [IDW-1:0]  idx,
   output logic            valid
);

   always_comb begin
      idx = '0;
      // Scan downward so the last assignment is the lowest set bit.
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDW'(i);
      end
   end

   assign valid = |vec;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and a bounded hold time.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  gnt_id,
   output logic            gnt_valid,
   output logic            timeout
);

   localparam int              CNTW     = $clog2(MAX_HOLD);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_HOLD - 1);

   state_t          state, state_nxt;
   logic [IDW-1:0]  ptr, ptr_nxt;
   logic [CNTW-1:0] cnt, cnt_nxt;
   logic [NREQ-1:0] grant_nxt;
   logic [IDW-1:0]  id_nxt;
   logic            valid_nxt;
   logic            timeout_nxt;

   logic [NREQ-1:0] req_rot;
   logic [IDW-1:0]  enc_idx;
   logic            enc_valid;
   logic [IDW-1:0]  win;
   logic            owner_req;
   logic            at_limit;

   assign req_rot = rotr(req, ptr);

   pri_enc8_lsb u_enc (
      .vec   (req_rot),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   // Index arithmetic is 3 bits wide, so the add wraps mod 8 for free.
   assign win       = enc_idx + ptr;
   assign owner_req = req[gnt_id];
   assign at_limit  = (cnt == CNT_LAST);

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      cnt_nxt     = cnt;
      grant_nxt   = grant;
      id_nxt      = gnt_id;
      valid_nxt   = gnt_valid;
      timeout_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            grant_nxt = '0;
            id_nxt    = '0;
            valid_nxt = 1'b0;
            if (en && enc_valid) begin
               state_nxt = ST_GRANT;
               grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << win;
               id_nxt    = win;
               valid_nxt = 1'b1;
               cnt_nxt   = '0;
            end
         end
         ST_GRANT: begin
            if (!at_limit) cnt_nxt = cnt + 1'b1;
            if (!owner_req || !en || at_limit) begin
               state_nxt   = ST_IDLE;
               grant_nxt   = '0;
               id_nxt      = '0;
               valid_nxt   = 1'b0;
               ptr_nxt     = gnt_id + 1'b1;
               // Only a release caused purely by the hold limit is reported.
               timeout_nxt = owner_req && en && at_limit;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         cnt       <= '0;
         grant     <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         cnt       <= cnt_nxt;
         grant     <= grant_nxt;
         gnt_id    <= id_nxt;
         gnt_valid <= valid_nxt;
         timeout   <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized traffic against a tenure-based model.
module tb_rr_arbiter8;

   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [7:0] req = 8'h00;
   logic [7:0] grant;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: current owner (-1 = none), rotation start, cycles held, last timeout.
   int m_owner;
   int m_ptr;
   int m_ten;
   bit m_tout;

   wire [12:0] outs = {grant, gnt_id, gnt_valid, timeout};

   rr_arbiter8 #(.MAX_HOLD(MH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .grant     (grant),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] expv(input int idx, input bit tout);
      logic [7:0] g;
      logic [2:0] id;
      if (idx < 0) return {8'h00, 3'd0, 1'b0, tout};
      g  = 8'h01 << idx;
      id = 3'(idx);
      return {g, id, 1'b1, tout};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      m_owner = -1;
      m_ptr   = 0;
      m_ten   = 0;
      m_tout  = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs that edge will sample.
   task automatic model_step();
      int w;
      if (m_owner < 0) begin
         m_tout = 1'b0;
         if (en && req != 8'h00) begin
            w = -1;
            for (int k = 0; k < 8; k++) begin
               if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
            end
            m_owner = w;
            m_ten   = 1;
         end
      end else if (!req[m_owner] || !en) begin
         m_ptr   = (m_owner + 1) % 8;
         m_owner = -1;
         m_tout  = 1'b0;
      end else if (m_ten == MH) begin
         m_ptr   = (m_owner + 1) % 8;
         m_owner = -1;
         m_tout  = 1'b1;
      end else begin
         m_ten++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      req = 8'hFF;
      tick();
      tick();
      n_checks++;
      if (outs !== expv(-1, 1'b0)) begin
         n_fail++;
         $display("FAIL reset_state: outs=%h expected %h", outs, expv(-1, 1'b0));
      end
      rst = 1'b0;
      req = 8'h00;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      en  = 1'b1;
      req = 8'b0000_0100;
      tick();
      n_checks++;
      if (outs !== expv(2, 1'b0)) begin
         n_fail++;
         $display("FAIL single_grant: outs=%h expected %h", outs, expv(2, 1'b0));
      end
      req = 8'h00;
      tick();
      n_checks++;
      if (outs !== expv(-1, 1'b0)) begin
         n_fail++;
         $display("FAIL single_release: outs=%h expected %h", outs, expv(-1, 1'b0));
      end
      // Requesters 2 and 3 both ask; the pointer now sits at 3.
      req = 8'b0000_1100;
      tick();
      n_checks++;
      if (outs !== expv(3, 1'b0)) begin
         n_fail++;
         $display("FAIL single_ptr3: outs=%h expected %h", outs, expv(3, 1'b0));
      end
      req = 8'h00;
      tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      en  = 1'b1;
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick();
         n_checks++;
         if (outs !== expv(k % 8, 1'b0)) begin
            n_fail++;
            $display("FAIL rr_grant%0d: outs=%h expected %h", k, outs, expv(k % 8, 1'b0));
         end
         req = 8'hFF & ~(8'h01 << (k % 8));
         tick();
         n_checks++;
         if (outs !== expv(-1, 1'b0)) begin
            n_fail++;
            $display("FAIL rr_bubble%0d: outs=%h expected %h", k, outs, expv(-1, 1'b0));
         end
         req = 8'hFF;
      end
      req = 8'h00;
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      en  = 1'b1;
      req = 8'b0000_0011;
      for (int c = 0; c < MH; c++) begin
         tick();
         n_checks++;
         if (outs !== expv(0, 1'b0)) begin
            n_fail++;
            $display("FAIL timeout_hold%0d: outs=%h expected %h", c, outs, expv(0, 1'b0));
         end
      end
      tick();
      n_checks++;
      if (outs !== expv(-1, 1'b1)) begin
         n_fail++;
         $display("FAIL timeout_pulse: outs=%h expected %h", outs, expv(-1, 1'b1));
      end
      tick();
      n_checks++;
      if (outs !== expv(1, 1'b0)) begin
         n_fail++;
         $display("FAIL timeout_next: outs=%h expected %h", outs, expv(1, 1'b0));
      end
      req = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_wraparound();
      do_reset();
      en  = 1'b1;
      req = 8'b0100_0000;
      tick();
      n_checks++;
      if (outs !== expv(6, 1'b0)) begin
         n_fail++;
         $display("FAIL wrap_grant6: outs=%h expected %h", outs, expv(6, 1'b0));
      end
      req = 8'b0100_0001;
      for (int c = 1; c < MH; c++) tick();
      n_checks++;
      if (outs !== expv(6, 1'b0)) begin
         n_fail++;
         $display("FAIL wrap_hold6: outs=%h expected %h", outs, expv(6, 1'b0));
      end
      tick();
      n_checks++;
      if (outs !== expv(-1, 1'b1)) begin
         n_fail++;
         $display("FAIL wrap_release: outs=%h expected %h", outs, expv(-1, 1'b1));
      end
      tick();
      n_checks++;
      if (outs !== expv(0, 1'b0)) begin
         n_fail++;
         $display("FAIL wrap_grant0: outs=%h expected %h", outs, expv(0, 1'b0));
      end
      req = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_enable_reset();
      do_reset();
      en  = 1'b1;
      req = 8'b0001_0000;
      tick();
      n_checks++;
      if (outs !== expv(4, 1'b0)) begin
         n_fail++;
         $display("FAIL en_grant: outs=%h expected %h", outs, expv(4, 1'b0));
      end
      en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (outs !== expv(-1, 1'b0)) begin
            n_fail++;
            $display("FAIL en_off%0d: outs=%h expected %h", c, outs, expv(-1, 1'b0));
         end
      end
      en  = 1'b1;
      req = 8'b0011_0000;
      tick();
      n_checks++;
      if (outs !== expv(5, 1'b0)) begin
         n_fail++;
         $display("FAIL en_resume: outs=%h expected %h", outs, expv(5, 1'b0));
      end
      // Asynchronous reset while requester 5 holds the grant.
      req = 8'hFF;
      rst = 1'b1;
      #1;
      n_checks++;
      if (outs !== expv(-1, 1'b0)) begin
         n_fail++;
         $display("FAIL rst_async: outs=%h expected %h", outs, expv(-1, 1'b0));
      end
      #1;
      rst = 1'b0;
      tick();
      n_checks++;
      if (outs !== expv(0, 1'b0)) begin
         n_fail++;
         $display("FAIL rst_ptr0: outs=%h expected %h", outs, expv(0, 1'b0));
      end
      // Owner drop and disable on the same edge: one release, pointer advances once.
      req = 8'hFE;
      en  = 1'b0;
      tick();
      n_checks++;
      if (outs !== expv(-1, 1'b0)) begin
         n_fail++;
         $display("FAIL drop_and_en: outs=%h expected %h", outs, expv(-1, 1'b0));
      end
      en  = 1'b1;
      req = 8'hFF;
      tick();
      n_checks++;
      if (outs !== expv(1, 1'b0)) begin
         n_fail++;
         $display("FAIL drop_and_en_next: outs=%h expected %h", outs, expv(1, 1'b0));
      end
      req = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_random();
      do_reset();
      en  = 1'b1;
      req = 8'h00;
      for (int c = 0; c < 600; c++) begin
         en = ($urandom_range(0, 11) != 0);
         if ($urandom_range(0, 2) == 0) req = 8'($urandom);
         model_step();
         tick();
         n_checks++;
         if (outs !== expv(m_owner, m_tout)) begin
            n_fail++;
            $display("FAIL random_cycle%0d: outs=%h expected %h (en=%b req=%h)",
                     c, outs, expv(m_owner, m_tout), en, req);
         end
      end
      req = 8'h00;
      en  = 1'b0;
      tick();
   endtask

   initial begin
      m_owner = -1;
      m_ptr   = 0;
      m_ten   = 0;
      m_tout  = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_wraparound();
      test_enable_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
